// File: rtl/flight_seq_pkg.sv
// -----------------------------------------------------------------------------
// flight_seq_pkg
// Shared types and constants for the flight-mode sequencer:
//   state_e        - 2-bit flight state, the encoding is visible on the mode output
//   THRST_W        - thrust datapath width
//   WDOG_W         - command watchdog counter width
//   *_DEF          - default timeout and ramp-step values for flight_seq
//   ramp_down()    - saturating thrust decrement used in failsafe
// -----------------------------------------------------------------------------
package flight_seq_pkg;

    localparam int unsigned THRST_W = 9;
    localparam int unsigned WDOG_W  = 26;

    localparam logic [WDOG_W-1:0]  TMO_LONG_DEF  = 26'h3FF_FFFF;
    localparam logic [WDOG_W-1:0]  TMO_SHORT_DEF = 26'h000_0FFF;
    localparam logic [THRST_W-1:0] RAMP_STEP_DEF = 9'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAL      = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_e;

    // Thrust minus step, clamped at zero so a small residue never wraps to full power.
    function automatic logic [THRST_W-1:0] ramp_down(input logic [THRST_W-1:0] thrst,
                                                     input logic [THRST_W-1:0] step);
        return (thrst < step) ? '0 : thrst - step;
    endfunction

endpackage

// File: rtl/flight_seq_wdog.sv
// -----------------------------------------------------------------------------
// wdog_timer
// Saturating command watchdog. Counts enabled cycles since the last clear and
// flags expiry when the timeout is reached.
//   clk, rst   - clock, asynchronous active-high reset
//   clr_i      - synchronous clear (wins over counting)
//   en_i       - count enable
//   tmo_i      - timeout in cycles (must be >= 1)
//   expired_o  - high while enabled and the timeout has been reached
// -----------------------------------------------------------------------------
module wdog_timer
    import flight_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WDOG_W-1:0] tmo_i,
    output logic              expired_o
);

    logic [WDOG_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q < tmo_i)) begin
            cnt_q <= cnt_q + WDOG_W'(1);
        end
    end

    // Expiry is flagged one count early: the sequencer registers the state change,
    // so the quiet period seen on its outputs is exactly tmo_i cycles after the
    // clearing cycle. The clear does not mask expiry, so a late command loses.
    assign expired_o = en_i && (cnt_q >= (tmo_i - WDOG_W'(1)));

endmodule

// File: rtl/flight_seq.sv
// -----------------------------------------------------------------------------
// flight_seq
// Arm / calibrate / fly / failsafe sequencer between the command unit and the
// flight controller. Gates commanded thrust, drives calibration handshakes and
// ramps thrust to zero if the wireless link goes quiet while armed.
//   clk, rst      - 50 MHz clock, asynchronous active-high reset
//   cmd_evt       - pulse per valid wireless command (feeds the watchdog)
//   arm_req       - pulse, request calibrate-and-arm
//   disarm        - pulse, immediate motors off from any state
//   cal_done      - pulse, inertial calibration finished
//   vld           - pulse, new inertial sample (paces the failsafe ramp)
//   thrst_cmd     - commanded thrust
//   strt_cal      - one-cycle calibration start pulse
//   inertial_cal  - high while calibrating
//   motors_off    - forces ESCs off (IDLE)
//   thrst         - registered thrust to the flight controller
//   failsafe      - high in FAILSAFE
//   mode          - current state encoding
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module flight_seq
    import flight_seq_pkg::*;
#(
    parameter bit                  FAST_SIM  = 1'b0,
    parameter logic [WDOG_W-1:0]   TMO_LONG  = TMO_LONG_DEF,
    parameter logic [WDOG_W-1:0]   TMO_SHORT = TMO_SHORT_DEF,
    parameter logic [THRST_W-1:0]  RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_evt,
    input  logic               arm_req,
    input  logic               disarm,
    input  logic               cal_done,
    input  logic               vld,
    input  logic [THRST_W-1:0] thrst_cmd,
    output logic               strt_cal,
    output logic               inertial_cal,
    output logic               motors_off,
    output logic [THRST_W-1:0] thrst,
    output logic               failsafe,
    output logic [1:0]         mode
);

    localparam logic [WDOG_W-1:0] TMO = FAST_SIM ? TMO_SHORT : TMO_LONG;

    state_e             state_q, state_d;
    logic [THRST_W-1:0] thrst_q, thrst_d;
    logic               strt_cal_q, strt_cal_d;
    logic               inertial_cal_q, motors_off_q, failsafe_q;
    logic               wd_clr, wd_en, wd_expired;

    // Watchdog runs only while armed; holding it clear elsewhere also gives the
    // clear-on-entry behaviour for free.
    assign wd_en  = (state_q == ST_ARMED);
    assign wd_clr = (state_q != ST_ARMED) || cmd_evt;

    wdog_timer u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .tmo_i     (TMO),
        .expired_o (wd_expired)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        thrst_d    = thrst_q;
        strt_cal_d = 1'b0;

        // disarm outranks every other event in every state.
        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:     if (arm_req)             state_d = ST_CAL;
                ST_CAL:      if (cal_done)            state_d = ST_ARMED;
                ST_ARMED:    if (wd_expired)          state_d = ST_FAILSAFE;
                ST_FAILSAFE: if (vld && thrst_q == '0) state_d = ST_IDLE;
                default:                              state_d = ST_IDLE;
            endcase
        end

        strt_cal_d = (state_q == ST_IDLE) && (state_d == ST_CAL);

        // Thrust is chosen by where we are going: zero on the ground, tracking
        // while armed (the entry cycle stays zero), frozen on failsafe entry and
        // ramped down on each inertial sample afterwards.
        unique case (state_d)
            ST_ARMED:    thrst_d = (state_q == ST_ARMED) ? thrst_cmd : '0;
            ST_FAILSAFE: thrst_d = (state_q == ST_FAILSAFE && vld) ?
                                   ramp_down(thrst_q, RAMP_STEP) : thrst_q;
            default:     thrst_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            thrst_q        <= '0;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            motors_off_q   <= 1'b1;
            failsafe_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            thrst_q        <= thrst_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= (state_d == ST_CAL);
            motors_off_q   <= (state_d == ST_IDLE);
            failsafe_q     <= (state_d == ST_FAILSAFE);
        end
    end

    assign strt_cal     = strt_cal_q;
    assign inertial_cal = inertial_cal_q;
    assign motors_off   = motors_off_q;
    assign thrst        = thrst_q;
    assign failsafe     = failsafe_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_flight_seq.sv
// -----------------------------------------------------------------------------
// tb_flight_seq
// Self-checking bench for flight_seq (FAST_SIM=1). A cycle-stamp reference
// model predicts every output each cycle; directed checks cover the listed
// scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_flight_seq;

    localparam int TMO  = 4095;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_evt, arm_req, disarm, cal_done, vld;
    logic [8:0] thrst_cmd;
    logic       strt_cal, inertial_cal, motors_off, failsafe;
    logic [8:0] thrst;
    logic [1:0] mode;

    always #5 clk = ~clk;

    flight_seq #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_evt      (cmd_evt),
        .arm_req      (arm_req),
        .disarm       (disarm),
        .cal_done     (cal_done),
        .vld          (vld),
        .thrst_cmd    (thrst_cmd),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .motors_off   (motors_off),
        .thrst        (thrst),
        .failsafe     (failsafe),
        .mode         (mode)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The watchdog is modelled as a cycle stamp of the last kick (cal_done or
    // cmd_evt); the link is dead once TMO cycles have elapsed since that stamp.
    int     m_mode;
    int     m_thrst;
    bit     m_strt;
    longint cyc;
    longint last_kick;

    task automatic model_reset();
        m_mode  = 0;
        m_thrst = 0;
        m_strt  = 0;
    endtask

    task automatic model_update();
        cyc++;
        m_strt = 0;
        if (disarm) begin
            m_mode  = 0;
            m_thrst = 0;
        end else begin
            case (m_mode)
                0: if (arm_req) begin m_mode = 1; m_strt = 1; end
                1: if (cal_done) begin m_mode = 2; last_kick = cyc; end
                2: begin
                    if (cyc - last_kick >= TMO) begin
                        m_mode = 3;
                    end else begin
                        m_thrst = int'(thrst_cmd);
                        if (cmd_evt) last_kick = cyc;
                    end
                end
                default: begin
                    if (vld) begin
                        if (m_thrst == 0) m_mode = 0;
                        else m_thrst = (m_thrst < STEP) ? 0 : m_thrst - STEP;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {17'd0, mode, motors_off, inertial_cal, failsafe, strt_cal, thrst};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [1:0] md;
        logic [8:0] th;
        md = m_mode[1:0];
        th = m_thrst[8:0];
        return {17'd0, md, (m_mode == 0), (m_mode == 1), (m_mode == 3), m_strt, th};
    endfunction

    // One clock: inputs already driven, model advances at the edge, outputs
    // compared 1 time unit later; pulse inputs are then dropped.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("outs", dut_vec(), exp_vec());
        cmd_evt  = 1'b0;
        arm_req  = 1'b0;
        disarm   = 1'b0;
        cal_done = 1'b0;
        vld      = 1'b0;
    endtask

    task automatic arm_and_cal();
        arm_req = 1'b1;
        step();
        cal_done = 1'b1;
        step();
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (failsafe !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"},  mode,         0);
        check({tag, "_moff"},  motors_off,   1);
        check({tag, "_thrst"}, thrst,        0);
        check({tag, "_strt"},  strt_cal,     0);
        check({tag, "_ical"},  inertial_cal, 0);
        check({tag, "_fs"},    failsafe,     0);
    endtask

    // Reset asserted mid-cycle, outputs checked before any further clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        logic saw_fs;

        cyc = 0;
        last_kick = 0;
        model_reset();
        rst = 1'b1;
        cmd_evt = 0; arm_req = 0; disarm = 0; cal_done = 0; vld = 0;
        thrst_cmd = '0;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // Arm, calibrate, track thrust, disarm from ARMED.
        arm_req = 1'b1;
        step();
        check("arm_strt", strt_cal, 1);
        check("arm_ical", inertial_cal, 1);
        check("arm_moff", motors_off, 0);
        step();
        check("arm_strt_once", strt_cal, 0);
        thrst_cmd = 9'h100;
        cal_done  = 1'b1;
        step();
        check("cal_mode", mode, 2);
        check("cal_ical", inertial_cal, 0);
        check("cal_thrst0", thrst, 0);
        step();
        check("track_thrst", thrst, 9'h100);
        disarm = 1'b1;
        step();
        check("dis_armed_mode", mode, 0);
        check("dis_armed_thrst", thrst, 0);
        check("dis_armed_moff", motors_off, 1);

        // Disarm from CAL.
        arm_req = 1'b1;
        step();
        disarm = 1'b1;
        step();
        check("dis_cal_mode", mode, 0);

        // Timeout with no commands, then saturating ramp.
        thrst_cmd = 9'd10;
        arm_and_cal();
        wait_fs(n);
        check("fs_latency", n, TMO);
        check("fs_entry_thrst", thrst, 10);
        vld = 1'b1; step(); check("ramp1", thrst, 6);
        vld = 1'b1; step(); check("ramp2", thrst, 2);
        vld = 1'b1; step(); check("ramp3", thrst, 0);
        check("ramp3_fs", failsafe, 1);
        vld = 1'b1; step();
        check("ramp_idle_mode", mode, 0);
        check("ramp_idle_moff", motors_off, 1);

        // Regular commands keep the link alive; a full gap trips the watchdog.
        thrst_cmd = 9'd37;
        arm_and_cal();
        saw_fs = 1'b0;
        for (int i = 1; i <= 52000; i++) begin
            if (i % 4000 == 0) cmd_evt = 1'b1;
            step();
            if (failsafe === 1'b1) saw_fs = 1'b1;
        end
        check("kick_no_fs", saw_fs, 0);
        wait_fs(n);
        check("gap_latency", n, TMO);

        // Failsafe ignores commands, arm requests and new thrust.
        cmd_evt = 1'b1; arm_req = 1'b1; thrst_cmd = 9'h1AB;
        step();
        check("fs_ign_mode", mode, 3);
        check("fs_ign_thrst", thrst, 37);
        cmd_evt = 1'b1;
        step();
        check("fs_ign_fs", failsafe, 1);
        k = 0;
        while (mode !== 2'd0 && k < 30) begin
            vld = 1'b1;
            step();
            k++;
        end
        check("ramp_len", k, 11);
        arm_req = 1'b1;
        step();
        check("rearm_mode", mode, 1);
        check("rearm_strt", strt_cal, 1);
        disarm = 1'b1; cal_done = 1'b1;
        step();
        check("dis_caldone_mode", mode, 0);
        check("dis_caldone_moff", motors_off, 1);

        // Disarm from FAILSAFE.
        arm_and_cal();
        wait_fs(n);
        check("fs2_latency", n, TMO);
        disarm = 1'b1;
        step();
        check("dis_fs_mode", mode, 0);
        check("dis_fs_thrst", thrst, 0);
        check("dis_fs_moff", motors_off, 1);

        // Asynchronous reset in FAILSAFE and in CAL.
        arm_and_cal();
        wait_fs(n);
        check("fs3_latency", n, TMO);
        async_reset("rst_fs");
        arm_req = 1'b1;
        step();
        check("pre_rst_cal", mode, 1);
        async_reset("rst_cal");

        // Randomized traffic: live link, dead link, live link.
        for (int seg = 0; seg < 3; seg++) begin
            int len;
            int kick_div;
            len      = (seg == 1) ? 4500 : 2000;
            kick_div = (seg == 1) ? 0 : 64;
            for (int i = 0; i < len; i++) begin
                thrst_cmd = 9'($urandom);
                arm_req   = ($urandom_range(15) == 0);
                cal_done  = ($urandom_range(15) == 0);
                vld       = ($urandom_range(3) == 0);
                disarm    = ($urandom_range(1999) == 0);
                cmd_evt   = (kick_div != 0) && ($urandom_range(kick_div - 1) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flight_seq.md
# flight_seq

Flight-mode sequencer between the command-configuration unit and the flight controller/ESC path. Owns the arm/calibrate/fly/failsafe state machine: issues the calibration start, holds the controller in calibration mode, gates commanded thrust, and forces motors off. A command watchdog triggers a controlled thrust ramp-down to zero if the wireless link goes quiet while armed.

## Interface
- FAST_SIM, default 0: when 1, use the short watchdog timeout (simulation only).
- TMO_LONG, default 26'h3FF_FFFF: watchdog timeout in clk cycles, used when FAST_SIM=0. At 50 MHz this is about 1.34 s.
- TMO_SHORT, default 26'h000_0FFF: watchdog timeout in clk cycles, used when FAST_SIM=1.
- RAMP_STEP, default 9'd4: thrust decrement per vld pulse while in failsafe.

- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- cmd_evt  in  1  one-cycle pulse for every valid command received over wireless
- arm_req  in  1  one-cycle pulse, request calibrate-and-arm
- disarm  in  1  one-cycle pulse, immediate motors off
- cal_done  in  1  one-cycle pulse from the inertial interface, calibration finished
- vld  in  1  one-cycle pulse, new inertial sample
- thrst_cmd  in  9  thrust commanded by cmd_cfg, unsigned
- strt_cal  out  1  one-cycle pulse to the inertial interface
- inertial_cal  out  1  high while calibration is in progress
- motors_off  out  1  forces the ESCs off
- thrst  out  9  thrust to the flight controller, unsigned, registered
- failsafe  out  1  high in the FAILSAFE state
- mode  out  2  current state encoding

## Operation
- States: IDLE=0, CAL=1, ARMED=2, FAILSAFE=3.
- IDLE:
  - motors_off=1, thrst=0.
  - arm_req → CAL, with strt_cal pulsed in the transition cycle.
- CAL:
  - inertial_cal=1, motors_off=0, thrst=0.
  - cal_done → ARMED.
  - disarm → IDLE.
- ARMED:
  - thrst follows thrst_cmd.
  - Every cmd_evt clears the watchdog.
  - Watchdog count reaching the selected timeout → FAILSAFE.
  - disarm → IDLE.
  - arm_req is ignored.
- FAILSAFE:
  - failsafe=1; thrst_cmd and cmd_evt are ignored.
  - On each vld: thrst ← thrst − RAMP_STEP, saturating at 0. No underflow when thrst < RAMP_STEP.
  - When thrst==0 on a vld cycle → IDLE.
  - disarm → IDLE immediately.
  - The link returning does not restore flight. The pilot must re-arm from IDLE.
- Watchdog:
  - 26-bit up-counter, active only in ARMED.
  - Cleared on entry to ARMED and on cmd_evt.
  - Saturates at the timeout value and never wraps.
- Priority for simultaneous events: disarm > cal_done / timeout > arm_req.
  - cmd_evt in the same cycle the timeout is reached: the timeout wins.

## Timing
- Reset values: mode=IDLE, motors_off=1, thrst=0, strt_cal=0, inertial_cal=0, failsafe=0, watchdog=0.
- Reset asserted mid-operation (any state): all outputs reach reset values asynchronously.
- Every output is a flop output; there are no combinational paths from inputs to outputs.
- arm_req at cycle N → strt_cal=1 at N+1 only, inertial_cal=1 and motors_off=0 from N+1.
- cal_done at N → inertial_cal=0 and mode=ARMED at N+1; thrst tracks thrst_cmd from N+2 onward (one-cycle register latency).
- Timeout: with the last cmd_evt at N, FAILSAFE is entered at N+TMO+1; thrst holds its last ARMED value at entry.
- disarm at N → motors_off=1, thrst=0, mode=IDLE at N+1, from every state.

## Structure
- flight_seq_pkg holds:
  - the state enum (2-bit);
  - TMO_LONG and TMO_SHORT defaults;
  - the RAMP_STEP default;
  - the thrust width constant (9).
- Sub-module wdog_timer: clear, enable and timeout inputs; a saturating counter with an expired output.
- The state machine and the thrust register stay in flight_seq.

## Test plan
- Reset, then arm_req → strt_cal high for exactly 1 cycle, inertial_cal=1, motors_off=0; cal_done → mode=2, and thrst_cmd=9'h100 gives thrst=9'h100 two cycles later.
- FAST_SIM=1, armed with thrst_cmd=9'd10 and no cmd_evt → failsafe=1 after 4096 cycles; vld pulses give thrst 6, 2, 0 (saturating); mode=IDLE and motors_off=1 after the vld that sees 0.
- Armed, cmd_evt every 4000 cycles (FAST_SIM=1) → never enters FAILSAFE over 50k cycles; a gap of 4096 cycles triggers FAILSAFE.
- disarm in CAL, ARMED and FAILSAFE → IDLE next cycle, thrst=0, motors_off=1; disarm with cal_done in the same cycle → IDLE.
- In FAILSAFE: cmd_evt and arm_req are ignored and thrst_cmd changes have no effect; after reaching IDLE, arm_req restarts calibration.
- rst asserted mid-CAL and mid-FAILSAFE → all outputs take reset values with no clock edge.
